// File: rtl/approx_add_err_recover.sv
// Exact-recovery back end for the approximate adder: recomputes a+b one SEG-bit
// segment per clock and reports which segments (and the carry-out) were wrong.
module approx_add_err_recover #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH/SEG-1:0] out_err_mask,
  output logic             out_cout_err,
  output logic             out_err
);

  localparam int NSEG = WIDTH / SEG;
  localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;

  generate
    if (WIDTH % SEG != 0) begin : g_bad_seg
      $error("approx_add_err_recover: WIDTH must be a multiple of SEG");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CORR, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic [WIDTH:0]    approx_reg;
  logic [WIDTH-1:0]  result_reg, result_next;
  logic [NSEG-1:0]   mask_reg, mask_next;
  logic              carry_reg;
  logic [IDXW-1:0]   seg_idx_reg;
  logic [SEG:0]      seg_sum;
  logic              last_seg;

  logic [WIDTH:0]    out_sum_reg;
  logic [NSEG-1:0]   out_mask_reg;
  logic              out_cout_err_reg;
  logic              out_err_reg;

  logic [SEG-1:0]    a_seg  [NSEG];
  logic [SEG-1:0]    b_seg  [NSEG];
  logic [SEG-1:0]    ap_seg [NSEG];

  // Only the segment selected by seg_idx_reg is replaced; the rest keep their value.
  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      assign a_seg[gi]  = a_reg[gi*SEG +: SEG];
      assign b_seg[gi]  = b_reg[gi*SEG +: SEG];
      assign ap_seg[gi] = approx_reg[gi*SEG +: SEG];
      assign result_next[gi*SEG +: SEG] = (seg_idx_reg == IDXW'(gi)) ?
                                          seg_sum[SEG-1:0] : result_reg[gi*SEG +: SEG];
      assign mask_next[gi] = (seg_idx_reg == IDXW'(gi)) ?
                             (seg_sum[SEG-1:0] != ap_seg[gi]) : mask_reg[gi];
    end
  endgenerate

  assign seg_sum  = {1'b0, a_seg[seg_idx_reg]} + {1'b0, b_seg[seg_idx_reg]}
                  + {{SEG{1'b0}}, carry_reg};
  assign last_seg = (seg_idx_reg == IDXW'(NSEG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = CORR;
      CORR:    if (last_seg) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg            <= '0;
      b_reg            <= '0;
      approx_reg       <= '0;
      result_reg       <= '0;
      mask_reg         <= '0;
      carry_reg        <= 1'b0;
      seg_idx_reg      <= '0;
      out_sum_reg      <= '0;
      out_mask_reg     <= '0;
      out_cout_err_reg <= 1'b0;
      out_err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg       <= a;
            b_reg       <= b;
            approx_reg  <= approx_sum;
            result_reg  <= '0;
            mask_reg    <= '0;
            carry_reg   <= 1'b0;
            seg_idx_reg <= '0;
          end
        end
        CORR: begin
          result_reg  <= result_next;
          mask_reg    <= mask_next;
          carry_reg   <= seg_sum[SEG];
          seg_idx_reg <= seg_idx_reg + IDXW'(1);
          // Final carry lands in the top bit and never feeds back into segment 0.
          if (last_seg) begin
            out_sum_reg      <= {seg_sum[SEG], result_next};
            out_mask_reg     <= mask_next;
            out_cout_err_reg <= seg_sum[SEG] ^ approx_reg[WIDTH];
            out_err_reg      <= (|mask_next) | (seg_sum[SEG] ^ approx_reg[WIDTH]);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum      = out_sum_reg;
  assign out_err_mask = out_mask_reg;
  assign out_cout_err = out_cout_err_reg;
  assign out_err      = out_err_reg;

endmodule

// File: tb/tb_approx_add_err_recover.sv
// Self-checking bench for approx_add_err_recover: directed cases, randomized
// operands against an exact-sum reference model, backpressure, reset and throughput.
module tb_approx_add_err_recover;
  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int NSEG  = WIDTH / SEG;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0]   approx_sum;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic [NSEG-1:0]  out_err_mask;
  logic             out_cout_err;
  logic             out_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  approx_add_err_recover #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_sum(approx_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_err_mask(out_err_mask),
    .out_cout_err(out_cout_err), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact sum by plain addition, then compare segment by segment.
  function automatic void ref_model(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                    input logic [WIDTH:0] rap, output logic [WIDTH:0] esum,
                                    output logic [NSEG-1:0] emask, output logic ecout,
                                    output logic eerr);
    esum = {1'b0, ra} + {1'b0, rb};
    for (int k = 0; k < NSEG; k++) emask[k] = (esum[k*SEG +: SEG] != rap[k*SEG +: SEG]);
    ecout = esum[WIDTH] ^ rap[WIDTH];
    eerr  = (|emask) | ecout;
  endfunction

  // Drives one transaction from IDLE and collects the result; lat counts the
  // accepting edge as edge 1, or is -1 on timeout.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                        input logic [WIDTH:0] tap, output logic [WIDTH:0] osum,
                        output logic [NSEG-1:0] omask, output logic ocout,
                        output logic oerr, output int lat);
    a = ta; b = tbv; approx_sum = tap; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); approx_sum = (WIDTH+1)'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    osum = out_sum; omask = out_err_mask; ocout = out_cout_err; oerr = out_err;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    a = 16'hABCD; b = 16'h1234; approx_sum = 17'h1FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_sum, out_err_mask, out_cout_err, out_err} !==
        {1'b0, 1'b1, 17'h0, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: valid=%0b ready=%0b sum=%h mask=%b cout=%0b err=%0b, want 0 1 0 0 0 0",
               out_valid, in_ready, out_sum, out_err_mask, out_cout_err, out_err);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%0b valid=%0b, want 1 0", in_ready, out_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_directed();
    logic [WIDTH:0]  tv_ap   [3] = '{17'h05555, 17'h000F0, 17'h00000};
    logic [WIDTH-1:0] tv_a   [3] = '{16'h1234, 16'h00FF, 16'hFFFF};
    logic [WIDTH-1:0] tv_b   [3] = '{16'h4321, 16'h0001, 16'h0001};
    logic [WIDTH:0]  tv_sum  [3] = '{17'h05555, 17'h00100, 17'h10000};
    logic [NSEG-1:0] tv_mask [3] = '{4'b0000, 4'b0110, 4'b0000};
    logic            tv_cout [3] = '{1'b0, 1'b0, 1'b1};
    logic            tv_err  [3] = '{1'b0, 1'b1, 1'b1};
    logic [WIDTH:0] s; logic [NSEG-1:0] m; logic c, e; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(tv_a[i], tv_b[i], tv_ap[i], s, m, c, e, lat);
      checks++;
      if (lat != NSEG + 1) begin
        errors++;
        $display("FAIL directed%0d_latency: got %0d edges, want %0d", i, lat, NSEG + 1);
      end
      checks++;
      if ({s, m, c, e} !== {tv_sum[i], tv_mask[i], tv_cout[i], tv_err[i]}) begin
        errors++;
        $display("FAIL directed%0d_result: sum=%h mask=%b cout=%0b err=%0b, want %h %b %0b %0b",
                 i, s, m, c, e, tv_sum[i], tv_mask[i], tv_cout[i], tv_err[i]);
      end
      $display("directed%0d a=%h b=%h approx=%h -> sum=%h mask=%b cout=%0b err=%0b lat=%0d",
               i, tv_a[i], tv_b[i], tv_ap[i], s, m, c, e, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH:0] s; logic [NSEG-1:0] m; logic c, e; int lat;
    a = 16'h1234; b = 16'h4321; approx_sum = 17'h05555; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_sum, out_err_mask, out_cout_err, out_err} !==
        {1'b0, 1'b1, 17'h0, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_async: valid=%0b ready=%0b sum=%h mask=%b cout=%0b err=%0b, want 0 1 0 0 0 0",
               out_valid, in_ready, out_sum, out_err_mask, out_cout_err, out_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h1234, 16'h4321, 17'h05555, s, m, c, e, lat);
    checks++;
    if ({s, m, c, e} !== {17'h05555, 4'b0000, 1'b0, 1'b0} || lat != NSEG + 1) begin
      errors++;
      $display("FAIL reset_mid_rerun: sum=%h mask=%b cout=%0b err=%0b lat=%0d, want 05555 0000 0 0 %0d",
               s, m, c, e, lat, NSEG + 1);
    end
    $display("reset_mid rerun -> sum=%h mask=%b lat=%0d", s, m, lat);
  endtask

  task automatic test_backpressure();
    int n;
    a = 16'h00FF; b = 16'h0001; approx_sum = 17'h000F0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL backpressure_wait: out_valid=0 after %0d cycles, want 1", n);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({out_valid, in_ready, out_sum, out_err_mask, out_cout_err, out_err} !==
          {1'b1, 1'b0, 17'h00100, 4'b0110, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL backpressure_hold%0d: valid=%0b ready=%0b sum=%h mask=%b cout=%0b err=%0b, want 1 0 00100 0110 0 1",
                 i, out_valid, in_ready, out_sum, out_err_mask, out_cout_err, out_err);
      end
      in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
      approx_sum = (WIDTH+1)'($urandom);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%0b ready=%0b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_idle: valid=%0b ready=%0b, want 0 1", out_valid, in_ready);
    end
    $display("backpressure held 6 cycles, released");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb; logic [WIDTH:0] rap, es, s;
    logic [NSEG-1:0] em, m; logic ec, ee, c, e; int lat;
    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom);
      rap = {1'b0, ra} + {1'b0, rb};
      if ($urandom_range(0, 3) != 0) rap = rap ^ (1 << $urandom_range(0, WIDTH));
      if ($urandom_range(0, 3) == 0) rap = rap ^ (WIDTH+1)'($urandom);
      ref_model(ra, rb, rap, es, em, ec, ee);
      run_op(ra, rb, rap, s, m, c, e, lat);
      checks++;
      if ({s, m, c, e} !== {es, em, ec, ee} || lat != NSEG + 1) begin
        errors++;
        $display("FAIL random%0d: sum=%h mask=%b cout=%0b err=%0b lat=%0d, want %h %b %0b %0b %0d",
                 i, s, m, c, e, lat, es, em, ec, ee, NSEG + 1);
      end
      $display("random%0d a=%h b=%h approx=%h -> sum=%h mask=%b cout=%0b err=%0b",
               i, ra, rb, rap, s, m, c, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a1, b1, a2, b2; logic [WIDTH:0] ap1, ap2, es1, es2, r1s, r2s;
    logic [NSEG-1:0] em1, em2, r1m, r2m; logic ec1, ee1, ec2, ee2, r1c, r1e, r2c, r2e;
    int t1, t2, n; logic got1, got2;
    a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); ap1 = (WIDTH+1)'($urandom);
    a2 = WIDTH'($urandom); b2 = WIDTH'($urandom); ap2 = {1'b0, a2} + {1'b0, b2} ^ 17'h00010;
    ref_model(a1, b1, ap1, es1, em1, ec1, ee1);
    ref_model(a2, b2, ap2, es2, em2, ec2, ee2);
    got1 = 1'b0; got2 = 1'b0;
    r1s = '0; r1m = '0; r1c = 1'b0; r1e = 1'b0; r2s = '0; r2m = '0; r2c = 1'b0; r2e = 1'b0;
    a = a1; b = b1; approx_sum = ap1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    t1 = cyc;
    a = a2; b = b2; approx_sum = ap2;
    n = 0;
    while (!in_ready && n < 40) begin
      if (out_valid) begin
        got1 = 1'b1; r1s = out_sum; r1m = out_err_mask; r1c = out_cout_err; r1e = out_err;
      end
      @(posedge clk); @(negedge clk);
      n++;
    end
    @(posedge clk); @(negedge clk);
    t2 = cyc;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    if (out_valid) begin
      got2 = 1'b1; r2s = out_sum; r2m = out_err_mask; r2c = out_cout_err; r2e = out_err;
    end
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (t2 - t1 != NSEG + 2) begin
      errors++;
      $display("FAIL b2b_spacing: second accept %0d cycles after first, want %0d", t2 - t1, NSEG + 2);
    end
    checks++;
    if (!got1 || {r1s, r1m, r1c, r1e} !== {es1, em1, ec1, ee1}) begin
      errors++;
      $display("FAIL b2b_first: seen=%0b sum=%h mask=%b cout=%0b err=%0b, want %h %b %0b %0b",
               got1, r1s, r1m, r1c, r1e, es1, em1, ec1, ee1);
    end
    checks++;
    if (!got2 || {r2s, r2m, r2c, r2e} !== {es2, em2, ec2, ee2}) begin
      errors++;
      $display("FAIL b2b_second: seen=%0b sum=%h mask=%b cout=%0b err=%0b, want %h %b %0b %0b",
               got2, r2s, r2m, r2c, r2e, es2, em2, ec2, ee2);
    end
    $display("back_to_back spacing=%0d first=%h second=%h", t2 - t1, r1s, r2s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_reset_mid();
    test_backpressure();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
